cpu_run_controller: RTL and testbench

// - Generates the single-cycle `enable` strobe for `cpu`. Each strobe advances `instruction_pointer` and commits one instruction.
// - Provides stop, single-step, slow-run and turbo-run modes, plus one instruction-pointer breakpoint.
// - Sits between the board controls (already edge-detected upstream) and the `cpu` enable input.

---
 rtl/cpu_run_controller.sv | 149 ++++++++++++++
 tb/tb_cpu_run_controller.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Run controller for the cpu: produces the one-cycle enable strobe and implements
// stop, single-step, slow/turbo free-run and a single instruction-pointer breakpoint.
module cpu_run_controller #(
    parameter int unsigned SLOW_DIV    = 25_000_000,
    parameter int unsigned FAST_DIV    = 250,
    parameter int unsigned CNT_W       = 25,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run_toggle,
    input  logic        step_req,
    input  logic        turbo,
    input  logic        bp_enable,
    input  logic [7:0]  bp_addr,
    input  logic [7:0]  instruction_pointer,
    output logic        cpu_enable,
    output logic        running,
    output logic        halted_bp,
    output logic [15:0] step_count
);

    localparam int unsigned SET_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'((ROM_LATENCY > 0) ? ROM_LATENCY - 1 : 0);

    typedef enum logic [2:0] {IDLE, RUN_WAIT, FIRE, SETTLE, BREAK} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] div_cnt, div_cnt_nxt;
    logic [CNT_W-1:0] div_last, div_last_nxt;
    logic [SET_W-1:0] settle_cnt, settle_nxt;
    logic             stop_pend, stop_nxt;
    logic             run_nxt;
    logic             exit_now;
    logic             enter_wait;
    logic [15:0]      step_cnt;

    always_comb begin
        state_nxt    = state;
        div_cnt_nxt  = div_cnt;
        div_last_nxt = div_last;
        settle_nxt   = settle_cnt;
        stop_nxt     = stop_pend;
        run_nxt      = running;
        exit_now     = 1'b0;
        enter_wait   = 1'b0;

        case (state)
            IDLE: begin
                if (run_toggle) begin
                    state_nxt  = RUN_WAIT;
                    run_nxt    = 1'b1;
                    enter_wait = 1'b1;
                end else if (step_req) begin
                    state_nxt = FIRE;
                    run_nxt   = 1'b0;
                end
            end
            RUN_WAIT: begin
                if (run_toggle) begin
                    state_nxt   = IDLE;
                    run_nxt     = 1'b0;
                    div_cnt_nxt = '0;
                end else if (div_cnt == div_last) begin
                    state_nxt   = FIRE;
                    div_cnt_nxt = '0;
                end else begin
                    div_cnt_nxt = div_cnt + CNT_W'(1);
                end
            end
            FIRE: begin
                stop_nxt = stop_pend | run_toggle;
                if (ROM_LATENCY > 0) begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end else begin
                    exit_now = 1'b1;
                end
            end
            SETTLE: begin
                stop_nxt = stop_pend | run_toggle;
                if (settle_cnt == SET_LAST) exit_now = 1'b1;
                else                        settle_nxt = settle_cnt + SET_W'(1);
            end
            BREAK: begin
                if (run_toggle) begin
                    state_nxt  = RUN_WAIT;
                    run_nxt    = 1'b1;
                    enter_wait = 1'b1;
                end else if (step_req) begin
                    state_nxt = FIRE;
                    run_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A toggle arriving in the decision cycle itself still counts as a stop request.
        if (exit_now) begin
            stop_nxt = 1'b0;
            if (stop_pend || run_toggle) begin
                state_nxt = IDLE;
                run_nxt   = 1'b0;
            end else if (running && bp_enable && (instruction_pointer == bp_addr)) begin
                state_nxt = BREAK;
                run_nxt   = 1'b0;
            end else if (running) begin
                state_nxt  = RUN_WAIT;
                enter_wait = 1'b1;
            end else begin
                state_nxt = IDLE;
            end
        end

        if (enter_wait) begin
            div_cnt_nxt  = '0;
            div_last_nxt = turbo ? FAST_LAST : SLOW_LAST;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            div_cnt    <= '0;
            div_last   <= '0;
            settle_cnt <= '0;
            stop_pend  <= 1'b0;
            running    <= 1'b0;
            cpu_enable <= 1'b0;
            halted_bp  <= 1'b0;
            step_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_cnt_nxt;
            div_last   <= div_last_nxt;
            settle_cnt <= settle_nxt;
            stop_pend  <= stop_nxt;
            running    <= run_nxt;
            cpu_enable <= (state_nxt == FIRE);
            halted_bp  <= (state_nxt == BREAK);
            if (state_nxt == FIRE) step_cnt <= step_cnt + 16'd1;
        end
    end

    assign step_count = step_cnt;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: strobe timing, modes, breakpoint,
// reset behaviour and counter wrap, against a timing model derived from the run rules.
module tb_cpu_run_controller;

    localparam int unsigned SLOW = 8;
    localparam int unsigned FAST = 2;
    localparam int unsigned RL   = 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        run_toggle = 1'b0;
    logic        step_req = 1'b0;
    logic        turbo = 1'b0;
    logic        bp_enable = 1'b0;
    logic [7:0]  bp_addr = 8'd0;
    logic [7:0]  instruction_pointer;
    logic        cpu_enable;
    logic        running;
    logic        halted_bp;
    logic [15:0] step_count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    logic [7:0]  ip_cnt = 8'd0;
    logic [7:0]  ip_zero = 8'd0;
    logic [15:0] exp_cnt = 16'd0;

    cpu_run_controller #(
        .SLOW_DIV(SLOW),
        .FAST_DIV(FAST),
        .CNT_W(4),
        .ROM_LATENCY(RL)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .run_toggle(run_toggle),
        .step_req(step_req),
        .turbo(turbo),
        .bp_enable(bp_enable),
        .bp_addr(bp_addr),
        .instruction_pointer(instruction_pointer),
        .cpu_enable(cpu_enable),
        .running(running),
        .halted_bp(halted_bp),
        .step_count(step_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // cpu model: IP advances once per strobe
    always @(posedge clk) if (cpu_enable) ip_cnt <= ip_cnt + 8'd1;
    assign instruction_pointer = ip_cnt - ip_zero;

    function automatic int unsigned period(input logic t);
        return (t ? FAST : SLOW) + 1 + RL;
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_run();
        run_toggle = 1'b1;
        tick(1);
        run_toggle = 1'b0;
    endtask

    task automatic pulse_step();
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
    endtask

    task automatic wait_strobe(input int unsigned limit, output int unsigned t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int unsigned i = 0; i <= limit; i++) begin
            if (cpu_enable === 1'b1) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
            tick(1);
        end
    endtask

    task automatic quiet(input int unsigned n, output bit seen);
        seen = 1'b0;
        repeat (n) begin
            tick(1);
            if (cpu_enable !== 1'b0) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b exp=0", cpu_enable); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (halted_bp !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted_bp); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", step_count); end
        resetn = 1'b1;
        tick(2);
    endtask

    task automatic test_step();
        pulse_step();
        exp_cnt++;
        checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL step_strobe got=%b exp=1", cpu_enable); end
        checks++; if (step_count !== exp_cnt) begin errors++; $display("FAIL step_count got=%0d exp=%0d", step_count, exp_cnt); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL step_running got=%b exp=0", running); end
        tick(1);
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL step_single got=%b exp=0", cpu_enable); end
        pulse_step();   // sampled while still settling: dropped
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL step_ignored got=%b exp=0", cpu_enable); end
        pulse_step();   // controller idle again: accepted
        exp_cnt++;
        checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL step_idle_again got=%b exp=1", cpu_enable); end
        checks++; if (step_count !== exp_cnt) begin errors++; $display("FAIL step_count2 got=%0d exp=%0d", step_count, exp_cnt); end
        tick(4);
    endtask

    task automatic test_run_spacing();
        int unsigned p, t, prev;
        bit ok, seen;
        logic cur;
        turbo = 1'b0;
        pulse_run();
        p = cyc;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_start got=%b exp=1", running); end
        wait_strobe(SLOW + 5, t, ok);
        exp_cnt++;
        checks++; if (!ok || t != p + SLOW) begin errors++; $display("FAIL run_first got=%0d exp=%0d", t, p + SLOW); end
        prev = t;
        cur  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) turbo = 1'b1;
            if (i == 6) turbo = 1'b0;
            cur = turbo;
            tick(1);
            wait_strobe(20, t, ok);
            exp_cnt++;
            checks++; if (!ok || t != prev + period(cur)) begin errors++; $display("FAIL run_gap%0d got=%0d exp=%0d", i, t - prev, period(cur)); end
            checks++; if (step_count !== exp_cnt) begin errors++; $display("FAIL run_count%0d got=%0d exp=%0d", i, step_count, exp_cnt); end
            prev = t;
        end
        tick(3);
        pulse_run();
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_stop got=%b exp=0", running); end
        quiet(30, seen);
        checks++; if (seen) begin errors++; $display("FAIL run_stop_quiet got=1 exp=0"); end
        turbo = 1'b0;
    endtask

    task automatic test_breakpoint();
        int unsigned p, t, prev;
        bit ok, seen;
        ip_zero   = ip_cnt;
        bp_enable = 1'b1;
        bp_addr   = 8'd3;
        turbo     = 1'b0;
        pulse_run();
        p = cyc;
        prev = p + SLOW - period(1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_strobe(20, t, ok);
            exp_cnt++;
            checks++; if (!ok || t != prev + period(1'b0)) begin errors++; $display("FAIL bp_strobe%0d got=%0d exp=%0d", i, t, prev + period(1'b0)); end
            prev = t;
            tick(1);
        end
        tick(1);
        checks++; if (halted_bp !== 1'b1) begin errors++; $display("FAIL bp_halted got=%b exp=1", halted_bp); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL bp_running got=%b exp=0", running); end
        checks++; if (step_count !== exp_cnt) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", step_count, exp_cnt); end
        quiet(50, seen);
        checks++; if (seen || halted_bp !== 1'b1) begin errors++; $display("FAIL bp_hold got=%b/%b exp=0/1", seen, halted_bp); end
        pulse_run();
        p = cyc;
        checks++; if (halted_bp !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL bp_resume got=%b/%b exp=0/1", halted_bp, running); end
        wait_strobe(20, t, ok);
        exp_cnt++;
        checks++; if (!ok || t != p + SLOW) begin errors++; $display("FAIL bp_4th got=%0d exp=%0d", t, p + SLOW); end
        prev = t;
        tick(1);
        wait_strobe(20, t, ok);
        exp_cnt++;
        checks++; if (!ok || t != prev + period(1'b0) || halted_bp !== 1'b0) begin errors++; $display("FAIL bp_5th got=%0d exp=%0d", t, prev + period(1'b0)); end
        pulse_run();    // stop request while the strobe is in flight
        checks++; if (cpu_enable !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL fire_stop_settle got=%b/%b exp=0/1", cpu_enable, running); end
        tick(1);
        checks++; if (running !== 1'b0 || step_count !== exp_cnt) begin errors++; $display("FAIL fire_stop got=%b/%0d exp=0/%0d", running, step_count, exp_cnt); end
        quiet(30, seen);
        checks++; if (seen) begin errors++; $display("FAIL fire_stop_quiet got=1 exp=0"); end
        bp_enable = 1'b0;
    endtask

    task automatic test_simultaneous();
        int unsigned p, t;
        bit ok, seen;
        run_toggle = 1'b1;
        step_req   = 1'b1;
        tick(1);
        run_toggle = 1'b0;
        step_req   = 1'b0;
        p = cyc;
        checks++; if (cpu_enable !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL simul_enter got=%b/%b exp=0/1", cpu_enable, running); end
        wait_strobe(20, t, ok);
        exp_cnt++;
        checks++; if (!ok || t != p + SLOW) begin errors++; $display("FAIL simul_first got=%0d exp=%0d", t, p + SLOW); end
        tick(3);
        pulse_run();
        quiet(20, seen);
        checks++; if (seen || running !== 1'b0) begin errors++; $display("FAIL simul_stop got=%b/%b exp=0/0", seen, running); end
    endtask

    task automatic test_reset_midrun();
        int unsigned t;
        bit ok, seen;
        turbo = 1'b1;
        pulse_run();
        wait_strobe(20, t, ok);
        tick(1);
        resetn = 1'b0;
        #1;
        exp_cnt = 16'd0;
        checks++; if (!ok || cpu_enable !== 1'b0 || running !== 1'b0 || halted_bp !== 1'b0 || step_count !== 16'd0)
            begin errors++; $display("FAIL reset_settle got=%b%b%b/%0d exp=000/0", cpu_enable, running, halted_bp, step_count); end
        tick(2);
        resetn = 1'b1;
        quiet(30, seen);
        checks++; if (seen || running !== 1'b0) begin errors++; $display("FAIL reset_after got=%b/%b exp=0/0", seen, running); end
        pulse_step();
        resetn = 1'b0;
        #1;
        checks++; if (cpu_enable !== 1'b0 || step_count !== 16'd0) begin errors++; $display("FAIL reset_fire got=%b/%0d exp=0/0", cpu_enable, step_count); end
        tick(2);
        resetn = 1'b1;
        tick(2);
        turbo = 1'b0;
    endtask

    task automatic test_random_steps();
        logic extra;
        for (int i = 0; i < 20; i++) begin
            tick($urandom_range(0, 4));
            bp_enable = 1'($urandom_range(0, 1));
            bp_addr   = instruction_pointer + 8'd1;
            extra     = 1'($urandom_range(0, 1));
            pulse_step();
            exp_cnt++;
            checks++; if (cpu_enable !== 1'b1 || step_count !== exp_cnt) begin errors++; $display("FAIL rstep%0d got=%b/%0d exp=1/%0d", i, cpu_enable, step_count, exp_cnt); end
            if (extra) pulse_step();
            else       tick(1);
            checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL rstep_single%0d got=%b exp=0", i, cpu_enable); end
            tick(1);
            checks++; if (halted_bp !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL rstep_nobreak%0d got=%b/%b exp=0/0", i, halted_bp, running); end
        end
        bp_enable = 1'b0;
    endtask

    task automatic test_random_run();
        int unsigned p, t, prev;
        bit ok;
        logic cur;
        turbo = 1'($urandom_range(0, 1));
        cur   = turbo;
        pulse_run();
        p = cyc;
        wait_strobe(20, t, ok);
        exp_cnt++;
        checks++; if (!ok || t != p + (cur ? FAST : SLOW)) begin errors++; $display("FAIL rrun_first got=%0d exp=%0d", t, p + (cur ? FAST : SLOW)); end
        prev = t;
        for (int i = 0; i < 12; i++) begin
            turbo = 1'($urandom_range(0, 1));
            cur   = turbo;
            tick(1);
            wait_strobe(20, t, ok);
            exp_cnt++;
            checks++; if (!ok || t != prev + period(cur) || step_count !== exp_cnt)
                begin errors++; $display("FAIL rrun_gap%0d got=%0d/%0d exp=%0d/%0d", i, t - prev, step_count, period(cur), exp_cnt); end
            prev = t;
        end
        pulse_run();
        tick(1);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rrun_stop got=%b exp=0", running); end
        turbo = 1'b0;
        tick(3);
    endtask

    task automatic test_wrap();
        force dut.step_cnt = 16'hFFFE;
        tick(1);
        release dut.step_cnt;
        exp_cnt = 16'hFFFE;
        tick(1);
        checks++; if (step_count !== exp_cnt) begin errors++; $display("FAIL wrap_preload got=%h exp=%h", step_count, exp_cnt); end
        pulse_step();
        exp_cnt++;
        checks++; if (step_count !== exp_cnt) begin errors++; $display("FAIL wrap_ffff got=%h exp=%h", step_count, exp_cnt); end
        tick(3);
        pulse_step();
        exp_cnt++;
        checks++; if (step_count !== 16'h0000 || step_count !== exp_cnt) begin errors++; $display("FAIL wrap_zero got=%h exp=0000", step_count); end
        tick(3);
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_spacing();
        test_breakpoint();
        test_simultaneous();
        test_random_steps();
        test_random_run();
        test_reset_midrun();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
